// File: rtl/mantissa_normalizer.sv
// Multi-cycle left normalizer for FMUL32 post-multiply mantissas.
// Shifts one bit per cycle, decrementing the exponent, until MSB=1.
module mantissa_normalizer #(
    parameter int DATA_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_mant,
    input  logic [EXP_W-1:0]          in_exp,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_mant,
    output logic [EXP_W-1:0]          out_exp,
    output logic [$clog2(DATA_W)-1:0] out_shift,
    output logic                      out_zero,
    output logic                      out_uflow
);

    localparam int SHIFT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state;
    logic [DATA_W-1:0]    mant_q;
    logic [EXP_W-1:0]     exp_q;
    logic [SHIFT_W-1:0]   shift_q;
    logic                 zero_q;
    logic                 uflow_q;

    // Handshake flags follow the state register directly.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Data outputs are the working registers; they hold in DONE and IDLE.
    assign out_mant  = mant_q;
    assign out_exp   = exp_q;
    assign out_shift = shift_q;
    assign out_zero  = zero_q;
    assign out_uflow = uflow_q;

    // Control FSM and datapath: capture, shift one bit per cycle, hand off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mant_q  <= '0;
            exp_q   <= '0;
            shift_q <= '0;
            zero_q  <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mant_q  <= in_mant;
                        exp_q   <= in_exp;
                        shift_q <= '0;
                        zero_q  <= 1'b0;
                        uflow_q <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (mant_q == '0) begin
                        // Zero has no leading one; report a clean zero result.
                        zero_q  <= 1'b1;
                        exp_q   <= '0;
                        shift_q <= '0;
                        state   <= DONE;
                    end else if (mant_q[DATA_W-1]) begin
                        state   <= DONE;
                    end else if (exp_q == '0) begin
                        // Stop before the exponent would wrap below zero.
                        uflow_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        mant_q  <= {mant_q[DATA_W-2:0], 1'b0};
                        exp_q   <= exp_q - 1'b1;
                        shift_q <= shift_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Self-checking bench for mantissa_normalizer.
// Directed cases plus random operands against a leading-zero-count model.
module tb_mantissa_normalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_mant;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_mant;
    logic [7:0]  out_exp;
    logic [4:0]  out_shift;
    logic        out_zero;
    logic        out_uflow;

    int n_vec = 0;
    int n_err = 0;

    mantissa_normalizer #(
        .DATA_W(24),
        .EXP_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mant  (in_mant),
        .in_exp   (in_exp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mant (out_mant),
        .out_exp  (out_exp),
        .out_shift(out_shift),
        .out_zero (out_zero),
        .out_uflow(out_uflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: count leading zeros, then limit by the exponent budget.
    function automatic void model(
        input  logic [23:0] m,
        input  logic [7:0]  e,
        output logic [23:0] em,
        output logic [7:0]  ee,
        output logic [4:0]  es,
        output logic        ez,
        output logic        eu,
        output int          lat
    );
        int lz;
        lz = 0;
        if (m == 24'd0) begin
            em = '0; ee = '0; es = '0; ez = 1'b1; eu = 1'b0; lat = 1;
            return;
        end
        while (m[23 - lz] == 1'b0) lz++;
        ez = 1'b0;
        if (lz <= int'(e)) begin
            em  = m << lz;
            ee  = 8'(int'(e) - lz);
            es  = 5'(lz);
            eu  = 1'b0;
            lat = lz + 1;
        end else begin
            em  = m << e;
            ee  = '0;
            es  = 5'(e);
            eu  = 1'b1;
            lat = int'(e) + 1;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_mant"},      out_mant,  0);
        chk({tag, "_exp"},       out_exp,   0);
        chk({tag, "_shift"},     out_shift, 0);
        chk({tag, "_zero"},      out_zero,  0);
        chk({tag, "_uflow"},     out_uflow, 0);
    endtask

    // One full operation: accept, wait for result, hold, handshake.
    task automatic do_op(input logic [23:0] m, input logic [7:0] e,
                         input int hold, input bit keep_valid);
        logic [23:0] em;
        logic [7:0]  ee;
        logic [4:0]  es;
        logic        ez;
        logic        eu;
        int          elat;
        int          lat;
        model(m, e, em, ee, es, ez, eu, elat);
        @(negedge clk);
        chk("pre_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 300) begin
            if (keep_valid) in_mant = 24'($urandom);
            @(negedge clk);
            lat++;
        end
        chk("done_seen", out_valid, 1);
        chk("latency",   lat,       elat);
        chk("mant",      out_mant,  em);
        chk("exp",       out_exp,   ee);
        chk("shift",     out_shift, es);
        chk("zero",      out_zero,  ez);
        chk("uflow",     out_uflow, eu);
        for (int i = 0; i < hold; i++) begin
            if (keep_valid) in_mant = 24'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready,  0);
            chk("hold_mant",  out_mant,  em);
            chk("hold_exp",   out_exp,   ee);
            chk("hold_shift", out_shift, es);
            chk("hold_flags", {out_zero, out_uflow}, {ez, eu});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_ready", in_ready,  1);
        chk("post_mant",  out_mant,  em);
    endtask

    initial begin
        logic [23:0] t;
        logic [23:0] m;
        logic [7:0]  e;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mant   = '0;
        in_exp    = '0;
        out_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        do_op(24'h800000, 8'd127, 0, 1'b0);
        do_op(24'h000001, 8'd127, 0, 1'b0);
        do_op(24'h000000, 8'd50,  0, 1'b0);
        do_op(24'h001000, 8'd5,   0, 1'b0);
        do_op(24'h000001, 8'd127, 10, 1'b1);
        do_op(24'h000400, 8'd13,  0, 1'b0);
        do_op(24'h400000, 8'd0,   2, 1'b0);

        // Abort mid-shift with an asynchronous reset.
        @(negedge clk);
        in_valid = 1'b1;
        in_mant  = 24'h000001;
        in_exp   = 8'd127;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_result", out_valid, 0);
        do_op(24'h800000, 8'd127, 0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            t = 24'($urandom);
            m = t >> $urandom_range(0, 24);
            if ($urandom_range(0, 1) == 0) e = 8'($urandom_range(0, 30));
            else e = 8'($urandom_range(0, 255));
            do_op(m, e, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
